// File: rtl/led_scanner_pkg.sv
// Shared constants for the LED scanner: mode encodings and the bar direction type.
package scanner_pkg;

  localparam logic [1:0] MODE_BOUNCE    = 2'b00;
  localparam logic [1:0] MODE_WRAP_UP   = 2'b01;
  localparam logic [1:0] MODE_WRAP_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD      = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Highest frame index of the bar's low bit.
  function automatic int pmax_of(input int n_leds, input int bar_w);
    return n_leds + bar_w - 2;
  endfunction

endpackage

// File: rtl/led_scanner_if.sv
// Control and LED-drive bundle between board logic (master) and one scanner bank (slave).
interface led_scanner_if #(
  parameter int N_LEDS = 10
);
  logic              EN;
  logic [1:0]        MODE;
  logic [1:0]        SPEED;
  logic [N_LEDS-1:0] LED_array;
  logic              STEP;
  logic              AT_EDGE;

  modport master (
    output EN, MODE, SPEED,
    input  LED_array, STEP, AT_EDGE
  );

  modport slave (
    input  EN, MODE, SPEED,
    output LED_array, STEP, AT_EDGE
  );
endinterface

// File: rtl/led_scanner_divider.sv
// Step-rate divider: counts enabled cycles and pulses TICK once per selected period.
module tick_divider
  import scanner_pkg::*;
#(
  parameter int DIV_MAX = 2500000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [1:0] SPEED,
  output logic       TICK
);

  localparam int CNT_W = (DIV_MAX < 1) ? 1 : $clog2(DIV_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_V = CNT_W'(DIV_MAX);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shifted;
  logic [CNT_W-1:0] limit;

  // A shift down to zero still means one cycle per step.
  always_comb begin
    shifted = DIV_V >> SPEED;
    limit   = (shifted == '0) ? '0 : shifted - CNT_W'(1);
  end

  // ">=" lets a speed-up below the current count fire on the next enabled cycle.
  assign TICK = EN && (cnt >= limit);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (TICK) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scanner.sv
// Night-rider scanner: a BAR_W-wide lit bar moving across N_LEDS LEDs in a
// virtual frame padded by BAR_W-1 positions on each side.
//
//   dir      | meaning
//   ---------+-------------------------------------------
//   DIR_UP   | bounce steps toward PMAX (reset state)
//   DIR_DOWN | bounce steps toward 0
module led_scanner
  import scanner_pkg::*;
#(
  parameter int N_LEDS  = 10,
  parameter int BAR_W   = 3,
  parameter int DIV_MAX = 2500000
) (
  input logic CLK,
  input logic RST_N,
  led_scanner_if.slave bus
);

  localparam int PMAX = pmax_of(N_LEDS, BAR_W);
  localparam int PW   = (PMAX < 1) ? 1 : $clog2(PMAX + 1);
  localparam logic [PW-1:0] PMAX_V = PW'(PMAX);

  logic              tick;
  logic [PW-1:0]     pos;
  logic [PW-1:0]     pos_nxt;
  dir_t              dir;
  dir_t              dir_nxt;
  logic              step;
  logic              step_nxt;
  logic              at_edge;
  logic              at_edge_nxt;
  logic [N_LEDS-1:0] leds;

  tick_divider #(
    .DIV_MAX(DIV_MAX)
  ) u_div (
    .CLK  (CLK),
    .RST_N(RST_N),
    .EN   (bus.EN),
    .SPEED(bus.SPEED),
    .TICK (tick)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pos     <= '0;
      dir     <= DIR_UP;
      step    <= 1'b0;
      at_edge <= 1'b0;
    end else begin
      pos     <= pos_nxt;
      dir     <= dir_nxt;
      step    <= step_nxt;
      at_edge <= at_edge_nxt;
    end
  end

  always_comb begin
    pos_nxt     = pos;
    dir_nxt     = dir;
    step_nxt    = 1'b0;
    at_edge_nxt = 1'b0;
    if (tick) begin
      case (bus.MODE)
        MODE_BOUNCE: begin
          // Reverse on the step that leaves an end, so ends get no dwell.
          if (dir == DIR_UP) begin
            if (pos == PMAX_V) begin
              pos_nxt = PMAX_V - PW'(1);
              dir_nxt = DIR_DOWN;
            end else begin
              pos_nxt = pos + PW'(1);
            end
          end else begin
            if (pos == '0) begin
              pos_nxt = PW'(1);
              dir_nxt = DIR_UP;
            end else begin
              pos_nxt = pos - PW'(1);
            end
          end
        end
        MODE_WRAP_UP: begin
          pos_nxt = (pos == PMAX_V) ? '0 : pos + PW'(1);
          dir_nxt = DIR_UP;
        end
        MODE_WRAP_DOWN: begin
          pos_nxt = (pos == '0) ? PMAX_V : pos - PW'(1);
          dir_nxt = DIR_DOWN;
        end
        default: begin
          pos_nxt = pos;
          dir_nxt = dir;
        end
      endcase
      step_nxt    = (bus.MODE != MODE_HOLD);
      at_edge_nxt = step_nxt && ((pos_nxt == '0) || (pos_nxt == PMAX_V));
    end
  end

  // LED i sits at frame index i+BAR_W-1; lit when inside [pos, pos+BAR_W-1].
  always_comb begin
    leds = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      leds[i] = (int'(pos) <= i + BAR_W - 1) && (i <= int'(pos));
    end
  end

  assign bus.LED_array = leds;
  assign bus.STEP      = step;
  assign bus.AT_EDGE   = at_edge;

endmodule
